ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative multi-cycle MULT/MULTU/DIV/DIVU responder for the EX stage, with HI/LO holding registers.
//  EX issues a request (i_start + funct code) and stalls the pipeline on o_busy. The unit answers with a one-cycle o_done pulse.
//  o_hi/o_lo are always readable and feed MFHI/MFLO via the EX result mux.
// PARAMETERS
//  NB_INPUT    32  operand / HI / LO width (even, >=8)
//  NB_CONTROL  6   width of funct/op code (same encoding as ALU control)
// PORTS
//  i_clk        in   1           single clock, rising edge
//  i_rst        in   1           reset: synchronous, active-high
//  i_start      in   1           request strobe (sampled only in IDLE)
//  i_op         in   NB_CONTROL  011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU
//  i_operand_a  in   NB_INPUT    rs: multiplicand / dividend; MTHI/MTLO data
//  i_operand_b  in   NB_INPUT    rt: multiplier / divisor
//  i_mthi       in   1           write i_operand_a to HI (IDLE only)
//  i_mtlo       in   1           write i_operand_a to LO (IDLE only)
//  o_busy       out  1           operation in flight; EX stalls while high
//  o_done       out  1           one-cycle pulse: HI/LO hold the new result
//  o_hi         out  NB_INPUT    HI register (remainder / product high word)
//  o_lo         out  NB_INPUT    LO register (quotient / product low word)
// BEHAVIOUR
//  Reset: state=IDLE; o_busy=0; o_done=0; o_hi=0; o_lo=0; counter=0. Applies mid-operation: the op is discarded and no o_done is issued.
//  FSM IDLE -> RUN -> FIX -> IDLE:
//   IDLE: i_start with a valid i_op latches |a|, |b| (signed ops) or raw a, b (unsigned ops).
//         It also latches the result signs, sets counter=0 and goes to RUN.
//         i_start with any other i_op is ignored (stay IDLE).
//   RUN: one radix-2 step per cycle, NB_INPUT cycles.
//        Multiply is shift-add into a 2*NB_INPUT accumulator. Divide is restoring shift-subtract.
//   FIX: negate the product, or the quotient/remainder, per latched signs. Write HI/LO. Go to IDLE.
//  Timing: start in cycle 0. o_busy is high in cycles 1..NB_INPUT+1. o_done and the new HI/LO appear in cycle NB_INPUT+2.
//  o_done is registered and is high for exactly one cycle. o_busy=0 in that cycle, so a back-to-back start is accepted.
//  Signed rules: quotient sign = sign(a)^sign(b); remainder sign = sign(a); product sign = sign(a)^sign(b).
//  Divide by zero (both DIV and DIVU): HI=a, LO={NB_INPUT{1'b1}}, normal latency.
//  DIV of most-negative value by -1: LO=most-negative value, HI=0, no trap.
//  i_start, i_mthi and i_mtlo are ignored while o_busy=1.
//  In IDLE, i_start has priority: if it is accepted, i_mthi/i_mtlo in the same cycle are ignored.
//  i_mthi and i_mtlo may fire together in IDLE. Both registers then take i_operand_a next edge.
//  HI/LO keep their old values until the FIX edge. They never show partial results.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: multiply RUN ends as soon as the remaining multiplier bits are all zero (minimum 1 RUN cycle).
//   o_done then arrives in cycle k+2, where k is the number of RUN cycles taken. Divide latency is unchanged.
//  Not defined: fixed latency NB_INPUT+2 for every operation.
// STRUCTURE
//  Package/include mips_ex_pkg holds:
//   - funct localparams FUNCT_MULT/MULTU/DIV/DIVU (shared with the decode/ALU-control logic);
//   - state encodings ST_IDLE/ST_RUN/ST_FIX.
//  One sub-module, muldiv_abs_neg: combinational conditional two's-complement negate, used on the inputs and in FIX.
// TESTING
//  1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; o_done exactly in cycle 34 (macro off).
//  2. MULT a=-3 b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT a=0 b=7 with macro on -> done in cycle 3.
//  3. DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7 b=2 -> LO=3, HI=1.
//  4. DIVU a=100 b=0 -> HI=0x64, LO=0xFFFFFFFF. DIV a=0x80000000 b=-1 -> LO=0x80000000, HI=0.
//  5. i_rst in RUN cycle 10 -> next cycle o_busy=0, HI=LO=0, no o_done. A new MULTU 6*7 -> LO=42.
//  6. i_start/i_mthi while busy -> ignored, result unaffected. i_mthi a=0x1234 in IDLE -> HI=0x1234 next cycle.

Source files
------------

// File: rtl/mips_ex_pkg.sv
// mips_ex_pkg: funct codes and FSM states shared by the EX-stage multiply/divide logic
package mips_ex_pkg;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;
  function automatic logic is_muldiv(input logic [5:0] op);
    return op == FUNCT_MULT || op == FUNCT_MULTU || op == FUNCT_DIV || op == FUNCT_DIVU;
  endfunction
endpackage

// File: rtl/muldiv_abs_neg.sv
// muldiv_abs_neg: conditional two's-complement negate (absolute value on inputs, sign fix on results)
module muldiv_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);
  assign result = neg ? -value : value;
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
// MULDIV_EARLY_OUT_EN: multiply RUN stops once no multiplier bits remain.
module ex_muldiv_unit
  import mips_ex_pkg::*;
#(
  parameter int NB_INPUT   = 32,
  parameter int NB_CONTROL = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NB_CONTROL-1:0] i_op,
  input  logic [NB_INPUT-1:0]   i_operand_a,
  input  logic [NB_INPUT-1:0]   i_operand_b,
  input  logic                  i_mthi,
  input  logic                  i_mtlo,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [NB_INPUT-1:0]   o_hi,
  output logic [NB_INPUT-1:0]   o_lo
);
  localparam int N  = NB_INPUT;
  localparam int CW = $clog2(N);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*N-1:0] acc, x, acc_nx, prod_fix;
  logic [N-1:0] y, abs_a, abs_b, quo_fix, rem_fix, diff;
  logic [N:0] rem_sh;
  logic is_div, neg_q, neg_r, dz, last, op_signed, op_div, ge;
  assign op_signed = i_op == FUNCT_MULT || i_op == FUNCT_DIV;
  assign op_div    = i_op == FUNCT_DIV || i_op == FUNCT_DIVU;
  muldiv_abs_neg #(.W(N))   u_abs_a (.value(i_operand_a), .neg(op_signed & i_operand_a[N-1]), .result(abs_a));
  muldiv_abs_neg #(.W(N))   u_abs_b (.value(i_operand_b), .neg(op_signed & i_operand_b[N-1]), .result(abs_b));
  muldiv_abs_neg #(.W(2*N)) u_prod  (.value(acc), .neg(neg_q), .result(prod_fix));
  muldiv_abs_neg #(.W(N))   u_quo   (.value(acc[N-1:0]), .neg(neg_q), .result(quo_fix));
  muldiv_abs_neg #(.W(N))   u_rem   (.value(acc[2*N-1:N]), .neg(neg_r), .result(rem_fix));
  // restoring divide keeps {remainder, quotient} in acc; remainder < divisor so the difference fits N bits
  always_comb begin
    rem_sh = acc[2*N-1:N-1];
    ge     = rem_sh >= {1'b0, y};
    diff   = N'(rem_sh - {1'b0, y});
    acc_nx = is_div ? {ge ? diff : rem_sh[N-1:0], acc[N-2:0], ge} : acc + (y[0] ? x : '0);
  end
`ifdef MULDIV_EARLY_OUT_EN
  assign last = cnt == CW'(N-1) || (!is_div && (y[N-1:1] == '0 || x == '0));
`else
  assign last = cnt == CW'(N-1);
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_hi   <= '0;
      o_lo   <= '0;
      cnt    <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE:
          if (i_start && is_muldiv(i_op)) begin
            x      <= {{N{1'b0}}, abs_a};
            y      <= abs_b;
            acc    <= op_div ? {{N{1'b0}}, abs_a} : '0;
            is_div <= op_div;
            neg_q  <= op_signed & (i_operand_a[N-1] ^ i_operand_b[N-1]);
            neg_r  <= op_signed & i_operand_a[N-1];
            dz     <= i_operand_b == '0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= ST_RUN;
          end else begin
            if (i_mthi) o_hi <= i_operand_a;
            if (i_mtlo) o_lo <= i_operand_a;
          end
        ST_RUN: begin
          acc <= acc_nx;
          x   <= x << 1;
          y   <= is_div ? y : y >> 1;
          cnt <= cnt + 1'b1;
          if (last) state <= ST_FIX;
        end
        ST_FIX: begin
          o_hi   <= is_div ? rem_fix : prod_fix[2*N-1:N];
          o_lo   <= is_div ? (dz ? '1 : quo_fix) : prod_fix[N-1:0];
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
  localparam int N = 32;
  logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_mthi = 1'b0, i_mtlo = 1'b0;
  logic [5:0] i_op = '0;
  logic [N-1:0] i_operand_a = '0, i_operand_b = '0;
  logic o_busy, o_done;
  logic [N-1:0] o_hi, o_lo;
  int checks = 0, errors = 0;
  localparam logic [5:0] OP_MULT = 6'b011000, OP_MULTU = 6'b011001, OP_DIV = 6'b011010, OP_DIVU = 6'b011011;

  ex_muldiv_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op),
    .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
    .i_mthi(i_mthi), .i_mtlo(i_mtlo),
    .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge i_clk);
      if (o_done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [5:0] op, input logic [N-1:0] a, input logic [N-1:0] b, output int cyc);
    @(negedge i_clk);
    i_op = op; i_operand_a = a; i_operand_b = b; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    wait_done(cyc);
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checks += 4;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    if (o_hi !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", o_hi); end
    if (o_lo !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", o_lo); end
    i_rst = 1'b0;
  endtask

  task automatic test_mult;
    int cyc, want;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    checks += 3;
    if (cyc != 34) begin errors++; $display("FAIL multu_latency got %0d want 34", cyc); end
    if (o_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", o_hi); end
    if (o_lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", o_lo); end
    run_op(OP_MULT, -32'sd3, 32'd5, cyc);
    checks += 2;
    if (o_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi got %h want ffffffff", o_hi); end
    if (o_lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_neg_lo got %h want fffffff1", o_lo); end
`ifdef MULDIV_EARLY_OUT_EN
    want = 3;
`else
    want = 34;
`endif
    run_op(OP_MULT, 32'd0, 32'd7, cyc);
    checks += 3;
    if (cyc != want) begin errors++; $display("FAIL mult_zero_latency got %0d want %0d", cyc, want); end
    if (o_hi !== '0) begin errors++; $display("FAIL mult_zero_hi got %h want 0", o_hi); end
    if (o_lo !== '0) begin errors++; $display("FAIL mult_zero_lo got %h want 0", o_lo); end
  endtask

  task automatic test_timing;
    int bad = 0, c34_busy = -1, c34_done = -1, c35_done = -1;
    @(negedge i_clk);
    i_op = OP_DIVU; i_operand_a = 32'd50; i_operand_b = 32'd7; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge i_clk);
      if (c <= 33 && (o_busy !== 1'b1 || o_done !== 1'b0)) bad++;
      if (c == 34) begin c34_busy = int'(o_busy); c34_done = int'(o_done); end
      if (c == 35) c35_done = int'(o_done);
    end
    checks += 6;
    if (bad != 0) begin errors++; $display("FAIL timing_busy_window got %0d bad cycles want 0", bad); end
    if (c34_done != 1) begin errors++; $display("FAIL timing_done_34 got %0d want 1", c34_done); end
    if (c34_busy != 0) begin errors++; $display("FAIL timing_busy_34 got %0d want 0", c34_busy); end
    if (c35_done != 0) begin errors++; $display("FAIL timing_done_pulse got %0d want 0", c35_done); end
    if (o_lo !== 32'd7) begin errors++; $display("FAIL divu50_lo got %h want 7", o_lo); end
    if (o_hi !== 32'd1) begin errors++; $display("FAIL divu50_hi got %h want 1", o_hi); end
  endtask

  task automatic test_div;
    int cyc;
    run_op(OP_DIV, -32'sd7, 32'd2, cyc);
    checks += 3;
    if (cyc != 34) begin errors++; $display("FAIL div_latency got %0d want 34", cyc); end
    if (o_lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", o_lo); end
    if (o_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", o_hi); end
    run_op(OP_DIVU, 32'd7, 32'd2, cyc);
    checks += 2;
    if (o_lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h want 3", o_lo); end
    if (o_hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want 1", o_hi); end
  endtask

  task automatic test_div_edge;
    int cyc;
    run_op(OP_DIVU, 32'd100, 32'd0, cyc);
    checks += 3;
    if (cyc != 34) begin errors++; $display("FAIL divz_latency got %0d want 34", cyc); end
    if (o_hi !== 32'h64) begin errors++; $display("FAIL divuz_hi got %h want 64", o_hi); end
    if (o_lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divuz_lo got %h want ffffffff", o_lo); end
    run_op(OP_DIV, -32'sd7, 32'd0, cyc);
    checks += 2;
    if (o_hi !== 32'hFFFFFFF9) begin errors++; $display("FAIL divz_hi got %h want fffffff9", o_hi); end
    if (o_lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo got %h want ffffffff", o_lo); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    checks += 2;
    if (o_lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", o_lo); end
    if (o_hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", o_hi); end
  endtask

  task automatic test_reset_mid;
    int cyc, seen = 0;
    @(negedge i_clk);
    i_op = OP_MULTU; i_operand_a = 32'hFFFFFFFF; i_operand_b = 32'hFFFFFFFF; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    checks += 3;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", o_busy); end
    if (o_hi !== '0) begin errors++; $display("FAIL rstmid_hi got %h want 0", o_hi); end
    if (o_lo !== '0) begin errors++; $display("FAIL rstmid_lo got %h want 0", o_lo); end
    for (int c = 0; c < 40; c++) begin
      if (o_done) seen++;
      @(negedge i_clk);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rstmid_no_done got %0d pulses want 0", seen); end
    run_op(OP_MULTU, 32'd6, 32'd7, cyc);
    checks += 2;
    if (o_lo !== 32'd42) begin errors++; $display("FAIL rstmid_new_lo got %h want 2a", o_lo); end
    if (o_hi !== 32'd0) begin errors++; $display("FAIL rstmid_new_hi got %h want 0", o_hi); end
  endtask

  task automatic test_mthi_mtlo;
    @(negedge i_clk);
    i_mthi = 1'b1; i_operand_a = 32'h1234;
    @(posedge i_clk);
    #1 i_mthi = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_hi !== 32'h1234) begin errors++; $display("FAIL mthi got %h want 1234", o_hi); end
    i_mthi = 1'b1; i_mtlo = 1'b1; i_operand_a = 32'hABCD;
    @(posedge i_clk);
    #1 begin i_mthi = 1'b0; i_mtlo = 1'b0; end
    @(negedge i_clk);
    checks += 2;
    if (o_hi !== 32'hABCD) begin errors++; $display("FAIL mthi_both got %h want abcd", o_hi); end
    if (o_lo !== 32'hABCD) begin errors++; $display("FAIL mtlo_both got %h want abcd", o_lo); end
  endtask

  task automatic test_busy_ignore;
    int cyc;
    @(negedge i_clk);
    i_op = OP_DIVU; i_operand_a = 32'd7; i_operand_b = 32'd2; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    i_op = OP_MULTU; i_operand_a = 32'hDEAD; i_operand_b = 32'd3; i_start = 1'b1; i_mthi = 1'b1; i_mtlo = 1'b1;
    @(posedge i_clk);
    #1 begin i_start = 1'b0; i_mthi = 1'b0; i_mtlo = 1'b0; end
    @(negedge i_clk);
    checks++;
    if (o_hi !== 32'hABCD) begin errors++; $display("FAIL busy_mthi_hi got %h want abcd", o_hi); end
    wait_done(cyc);
    checks += 3;
    if (cyc != 28) begin errors++; $display("FAIL busy_latency got %0d want 28", cyc); end
    if (o_lo !== 32'd3) begin errors++; $display("FAIL busy_lo got %h want 3", o_lo); end
    if (o_hi !== 32'd1) begin errors++; $display("FAIL busy_hi got %h want 1", o_hi); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    run_op(OP_MULTU, 32'd3, 32'd4, cyc);
    checks += 2;
    if (o_lo !== 32'd12) begin errors++; $display("FAIL b2b_first_lo got %h want c", o_lo); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_done_busy got %b want 0", o_busy); end
    i_op = OP_DIVU; i_operand_a = 32'd9; i_operand_b = 32'd4; i_start = 1'b1; i_mthi = 1'b1;
    @(posedge i_clk);
    #1 begin i_start = 1'b0; i_mthi = 1'b0; end
    @(negedge i_clk);
    checks += 2;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got %b want 1", o_busy); end
    if (o_hi !== 32'd0) begin errors++; $display("FAIL b2b_start_priority got %h want 0", o_hi); end
    wait_done(cyc);
    checks += 3;
    if (cyc != 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", cyc); end
    if (o_lo !== 32'd2) begin errors++; $display("FAIL b2b_lo got %h want 2", o_lo); end
    if (o_hi !== 32'd1) begin errors++; $display("FAIL b2b_hi got %h want 1", o_hi); end
  endtask

  task automatic test_invalid_op;
    int seen = 0;
    @(negedge i_clk);
    i_op = 6'b100000; i_operand_a = 32'd5; i_operand_b = 32'd5; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL invalid_busy got %b want 0", o_busy); end
    for (int c = 0; c < 40; c++) begin
      if (o_done) seen++;
      @(negedge i_clk);
    end
    checks += 2;
    if (seen != 0) begin errors++; $display("FAIL invalid_done got %0d pulses want 0", seen); end
    if (o_lo !== 32'd2) begin errors++; $display("FAIL invalid_lo got %h want 2", o_lo); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_timing;
    test_div;
    test_div_edge;
    test_reset_mid;
    test_mthi_mtlo;
    test_busy_ignore;
    test_back_to_back;
    test_invalid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
